uart_tx_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer sharing one UART transmitter (my_UART_TX class core) among N requesters.

---
 rtl/uart_tx_arbiter.sv | 100 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX core among N_REQ byte producers
// Ports: CLK/RST (sync, active-high); REQ_VALID/REQ_DATA/REQ_LAST in, REQ_READY out per requester;
//   GRANT one-hot owner; TX_START/TX_DATA to the TX core, TX_BUSY from it; ERR start-timeout pulse.
// Optional macro UART_ARB_LOCK_EN: packet lock keeps the grant until a REQ_LAST=1 byte completes.
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int START_TO = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ_VALID,
  input  logic [N_REQ*DATA_W-1:0]   REQ_DATA,
  input  logic [N_REQ-1:0]          REQ_LAST,
  output logic [N_REQ-1:0]          REQ_READY,
  output logic [N_REQ-1:0]          GRANT,
  output logic                      TX_START,
  output logic [DATA_W-1:0]         TX_DATA,
  input  logic                      TX_BUSY,
  output logic                      ERR
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(START_TO + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win, win_q;
  logic [CW-1:0] cnt;
  logic [N_REQ-1:0] elig;
  logic found, timeout, done, rel;
`ifdef UART_ARB_LOCK_EN
  logic lock, last_q;
  // while locked only the packet owner (still flagged in GRANT) may compete
  assign elig = lock ? (REQ_VALID & GRANT) : REQ_VALID;
  assign rel  = timeout | (done & last_q);
`else
  logic unused_last;
  assign unused_last = ^REQ_LAST;
  assign elig = REQ_VALID;
  assign rel  = timeout | done;
`endif
  assign timeout = (state == WAIT_BUSY) && !TX_BUSY && (cnt == CW'(START_TO));
  assign done    = (state == WAIT_DONE) && !TX_BUSY;
  // scan ptr+N down to ptr+1 so the nearest eligible index after ptr is kept
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = N_REQ; i >= 1; i--)
      if (elig[PW'((int'(ptr) + i) % N_REQ)]) begin
        win   = PW'((int'(ptr) + i) % N_REQ);
        found = 1'b1;
      end
  end
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else     state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = (found && !TX_BUSY) ? LAUNCH : IDLE;
      LAUNCH:    state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = TX_BUSY ? WAIT_DONE : timeout ? IDLE : WAIT_BUSY;
      default:   state_nx = TX_BUSY ? WAIT_DONE : IDLE;
    endcase
  end
  always_comb begin
    TX_START  = (state == LAUNCH);
    REQ_READY = TX_START ? GRANT : '0;
    ERR       = timeout;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      GRANT   <= '0;
      TX_DATA <= '0;
      ptr     <= PW'(N_REQ - 1);
      win_q   <= '0;
      cnt     <= '0;
`ifdef UART_ARB_LOCK_EN
      lock    <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      if (state == IDLE && state_nx == LAUNCH) begin
        GRANT   <= N_REQ'(1) << win;
        TX_DATA <= REQ_DATA[win*DATA_W +: DATA_W];
        win_q   <= win;
`ifdef UART_ARB_LOCK_EN
        last_q  <= REQ_LAST[win];
`endif
      end
      cnt <= (state == LAUNCH) ? '0 : (state == WAIT_BUSY && cnt != CW'(START_TO)) ? cnt + 1'b1 : cnt;
      if (rel) begin
        GRANT <= '0;
        ptr   <= win_q;
      end
`ifdef UART_ARB_LOCK_EN
      lock <= rel ? 1'b0 : done ? 1'b1 : lock;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter with a behavioural TX core model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, TO = 16;
  logic clk = 1'b0, rst = 1'b1, tx_busy = 1'b0;
  logic [N-1:0] valid = '0, last = '1, ready, grant;
  logic [N*W-1:0] data = '0;
  logic tx_start, err;
  logic [W-1:0] tx_data;
  typedef struct {int req; logic [W-1:0] data;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, n_start = 0, n_errp = 0, cyc = 0, t_start = 0;
  int busy_dly = 3, busy_len = 8, dcnt = 0, hcnt = 0;
  bit never_busy = 1'b0, timed_out;
  logic [N-1:0] drop_mask = '1;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .START_TO(TO)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(valid), .REQ_DATA(data), .REQ_LAST(last),
    .REQ_READY(ready), .GRANT(grant), .TX_START(tx_start), .TX_DATA(tx_data),
    .TX_BUSY(tx_busy), .ERR(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // TX core model: busy rises busy_dly cycles after the start strobe, holds busy_len cycles
  always @(posedge clk)
    if (rst) begin
      tx_busy <= 1'b0; dcnt <= 0; hcnt <= 0;
    end else if (tx_start && !never_busy) dcnt <= busy_dly;
    else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin tx_busy <= 1'b1; hcnt <= busy_len; end
    end else if (hcnt > 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) tx_busy <= 1'b0;
    end

  // scoreboard: every launch is matched against the next expected byte and requester
  always @(negedge clk)
    if (!rst) begin
      n_cmp++;
      if (tx_start) begin
        n_start++;
        t_start = cyc;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_start got data=%h ready=%b, expected no launch", tx_data, ready);
        end else begin
          mon_e = q.pop_front();
          if (tx_data !== mon_e.data || ready !== (N'(1) << mon_e.req) || grant !== (N'(1) << mon_e.req)) begin
            n_err++;
            $display("FAIL launch got data=%h ready=%b grant=%b, expected data=%h req=%0d",
                     tx_data, ready, grant, mon_e.data, mon_e.req);
          end
        end
      end else if (ready !== '0) begin
        n_err++;
        $display("FAIL stray_ready got ready=%b, expected 0000", ready);
      end
      if (err) begin
        n_errp++;
        n_cmp++;
        if (cyc - t_start != TO + 1) begin
          n_err++;
          $display("FAIL err_delay got %0d cycles, expected %0d", cyc - t_start, TO + 1);
        end
      end
    end

  task automatic cyc_step();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) if (drop_mask[i] && ready[i]) valid[i] = 1'b0;
  endtask

  task automatic run(input int target, input int budget);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      cyc_step();
      if (n_start >= target && grant == '0 && !tx_busy) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic end_checks(input string name);
    n_cmp++;
    if (timed_out || q.size() != 0) begin
      n_err++;
      $display("FAIL %s_complete got timeout=%0d pending=%0d, expected 0/0", name, timed_out, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if ({ready, grant, tx_start, tx_data, err} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs got ready=%b grant=%b start=%b data=%h err=%b, expected all 0",
                 ready, grant, tx_start, tx_data, err);
      end
    end
    rst = 1'b0;
    repeat (3) begin
      cyc_step();
      n_cmp++;
      if (grant !== '0 || tx_start !== 1'b0) begin
        n_err++;
        $display("FAIL idle_no_valid got grant=%b start=%b, expected 0000/0", grant, tx_start);
      end
    end
  endtask

  task automatic test_single();
    int base = n_start;
    bit seen = 1'b0;
    busy_len = 100;
    timed_out = 1'b1;
    data[7:0] = 8'h31;
    valid = 4'b0001;
    q.push_back('{0, 8'h31});
    for (int k = 0; k < 300; k++) begin
      cyc_step();
      if (tx_busy) begin
        seen = 1'b1;
        n_cmp++;
        if (grant !== 4'b0001) begin
          n_err++;
          $display("FAIL single_grant got grant=%b, expected 0001", grant);
        end
      end
      if (seen && grant == '0) begin timed_out = 1'b0; break; end
    end
    end_checks("single");
    n_cmp++;
    if (n_start - base != 1) begin
      n_err++;
      $display("FAIL single_starts got %0d, expected 1", n_start - base);
    end
    busy_len = 8;
  endtask

  task automatic test_round_robin();
    int base;
    pulse_reset();
    base = n_start;
    drop_mask = '0;
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) q.push_back('{i % N, 8'hA0 + W'(i % N)});
    for (int k = 0; k < 400 && n_start < base + 5; k++) cyc_step();
    valid = '0;
    drop_mask = '1;
    run(base + 5, 200);
    end_checks("round_robin");
    n_cmp++;
    if (n_start - base != 5) begin
      n_err++;
      $display("FAIL rr_starts got %0d, expected 5", n_start - base);
    end
  endtask

  task automatic test_timeout();
    int base, errs;
    pulse_reset();
    base = n_start;
    errs = n_errp;
    never_busy = 1'b1;
    timed_out = 1'b1;
    data[15:0] = {8'h66, 8'h55};
    valid = 4'b0011;
    q.push_back('{0, 8'h55});
    q.push_back('{1, 8'h66});
    for (int k = 0; k < 400; k++) begin
      cyc_step();
      if (n_errp > errs) never_busy = 1'b0;
      if (n_start >= base + 2 && grant == '0 && !tx_busy) begin timed_out = 1'b0; break; end
    end
    never_busy = 1'b0;
    end_checks("timeout");
    n_cmp++;
    if (n_errp - errs != 1) begin
      n_err++;
      $display("FAIL err_count got %0d, expected 1", n_errp - errs);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_reset();
    timed_out = 1'b1;
    data[7:0] = 8'h77;
    valid = 4'b0001;
    q.push_back('{0, 8'h77});
    for (int k = 0; k < 200; k++) begin
      cyc_step();
      if (tx_busy) begin timed_out = 1'b0; break; end
    end
    end_checks("reach_wait_done");
    rst = 1'b1;
    cyc_step();
    n_cmp++;
    if ({ready, grant, tx_start, tx_data, err} !== '0) begin
      n_err++;
      $display("FAIL mid_reset got ready=%b grant=%b start=%b data=%h err=%b, expected all 0",
               ready, grant, tx_start, tx_data, err);
    end
    @(negedge clk);
    rst = 1'b0;
    base = n_start;
    data[15:0] = {8'h11, 8'h10};
    valid = 4'b0011;
    q.push_back('{0, 8'h10});
    q.push_back('{1, 8'h11});
    run(base + 2, 300);
    end_checks("after_mid_reset");
  endtask

  task automatic test_packet();
    int base, idx = 0;
    bit seeded = 1'b0;
    pulse_reset();
    base = n_start;
    timed_out = 1'b1;
    drop_mask = '0;
    data[15:8] = 8'hD1;
    last[1] = 1'b0;
    valid = 4'b0010;
`ifdef UART_ARB_LOCK_EN
    q.push_back('{1, 8'hD1}); q.push_back('{1, 8'hD2}); q.push_back('{1, 8'hD3}); q.push_back('{0, 8'hC0});
`else
    q.push_back('{1, 8'hD1}); q.push_back('{0, 8'hC0}); q.push_back('{1, 8'hD2}); q.push_back('{1, 8'hD3});
`endif
    for (int k = 0; k < 600; k++) begin
      cyc_step();
      if (ready[1]) begin
        idx++;
        if (idx == 3) valid[1] = 1'b0;
        else begin
          data[15:8] = W'(8'hD1 + idx);
          last[1] = (idx == 2);
        end
      end
      if (ready[0]) valid[0] = 1'b0;
      if (n_start >= base + 1 && !seeded) begin
        data[7:0] = 8'hC0;
        valid[0] = 1'b1;
        seeded = 1'b1;
      end
      if (n_start >= base + 4 && grant == '0 && !tx_busy) begin timed_out = 1'b0; break; end
    end
    drop_mask = '1;
    last = '1;
    end_checks("packet");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d, expected bench completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid();
    test_packet();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
